// File: rtl/dcounter_sync.sv
// Push-button up/down counter: each raw active-low button is synchronised, debounced
// and edge-detected on clk; the count wraps or saturates and reports terminal/overflow status.
module dcounter_sync #(
    parameter int N               = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int WRAP            = 1,
    parameter int INIT            = 0
) (
    input  logic         clk,
    input  logic         btn_reset,
    input  logic         btn_increment,
    input  logic         btn_decrement,
    output logic [N-1:0] count,
    output logic         at_max,
    output logic         at_min,
    output logic         overflow,
    output logic         underflow
);

    localparam int               CNT_W    = 24;
    localparam logic [CNT_W-1:0] DB_LEN   = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [N-1:0]     MAX_CNT  = {N{1'b1}};
    localparam logic [N-1:0]     ZERO_CNT = '0;
    localparam logic [N-1:0]     ONE_CNT  = N'(1);
    localparam logic [N-1:0]     INIT_CNT = N'(INIT);

    typedef enum logic [1:0] {
        RELEASED        = 2'd0,
        PRESS_PENDING   = 2'd1,
        PRESSED         = 2'd2,
        RELEASE_PENDING = 2'd3
    } db_state_t;

    // Index 0 is the increment button, index 1 the decrement button.
    logic [1:0] btn_raw;
    logic [1:0] press;

    assign btn_raw = {btn_decrement, btn_increment};

    for (genvar b = 0; b < 2; b++) begin : g_btn
        logic             sync1_q;
        logic             s_q;
        db_state_t        state_q;
        db_state_t        state_d;
        logic [CNT_W-1:0] dbcnt_q;
        logic [CNT_W-1:0] dbcnt_d;
        logic [CNT_W-1:0] dbcnt_inc;
        logic             press_q;
        logic             press_d;

        // Synchroniser: resets to the released level so reset never looks like a press.
        always_ff @(posedge clk or negedge btn_reset) begin
            if (!btn_reset) begin
                sync1_q <= 1'b1;
                s_q     <= 1'b1;
            end else begin
                sync1_q <= btn_raw[b];
                s_q     <= sync1_q;
            end
        end

        always_ff @(posedge clk or negedge btn_reset) begin
            if (!btn_reset) begin
                state_q <= RELEASED;
                dbcnt_q <= '0;
                press_q <= 1'b0;
            end else begin
                state_q <= state_d;
                dbcnt_q <= dbcnt_d;
                press_q <= press_d;
            end
        end

        assign dbcnt_inc = dbcnt_q + 1'b1;

        // The sample that leaves a stable state counts as the first of the run.
        always_comb begin
            state_d = state_q;
            dbcnt_d = dbcnt_q;
            press_d = 1'b0;
            case (state_q)
                RELEASED: begin
                    if (!s_q) begin
                        if (DB_LEN == 1) begin
                            state_d = PRESSED;
                            press_d = 1'b1;
                            dbcnt_d = '0;
                        end else begin
                            state_d = PRESS_PENDING;
                            dbcnt_d = 1;
                        end
                    end
                end
                PRESS_PENDING: begin
                    if (s_q) begin
                        state_d = RELEASED;
                        dbcnt_d = '0;
                    end else if (dbcnt_inc == DB_LEN) begin
                        state_d = PRESSED;
                        press_d = 1'b1;
                        dbcnt_d = '0;
                    end else begin
                        dbcnt_d = dbcnt_inc;
                    end
                end
                PRESSED: begin
                    if (s_q) begin
                        if (DB_LEN == 1) begin
                            state_d = RELEASED;
                            dbcnt_d = '0;
                        end else begin
                            state_d = RELEASE_PENDING;
                            dbcnt_d = 1;
                        end
                    end
                end
                RELEASE_PENDING: begin
                    // Bouncing back low during release is not a new press: no pulse here.
                    if (!s_q) begin
                        state_d = PRESSED;
                        dbcnt_d = '0;
                    end else if (dbcnt_inc == DB_LEN) begin
                        state_d = RELEASED;
                        dbcnt_d = '0;
                    end else begin
                        dbcnt_d = dbcnt_inc;
                    end
                end
                default: begin
                    state_d = RELEASED;
                    dbcnt_d = '0;
                end
            endcase
        end

        assign press[b] = press_q;
    end

    // Returns {limit_hit, next_count}; arithmetic stays N bits wide.
    function automatic logic [N:0] step_up(input logic [N-1:0] c);
        if (c == MAX_CNT) begin
            return {1'b1, (WRAP != 0) ? ZERO_CNT : MAX_CNT};
        end
        return {1'b0, c + ONE_CNT};
    endfunction

    function automatic logic [N:0] step_down(input logic [N-1:0] c);
        if (c == ZERO_CNT) begin
            return {1'b1, (WRAP != 0) ? MAX_CNT : ZERO_CNT};
        end
        return {1'b0, c - ONE_CNT};
    endfunction

    logic [N-1:0] count_q;
    logic [N-1:0] count_d;
    logic         overflow_q;
    logic         overflow_d;
    logic         underflow_q;
    logic         underflow_d;

    always_comb begin
        count_d     = count_q;
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
        case (press)
            2'b01:   {overflow_d, count_d}  = step_up(count_q);
            2'b10:   {underflow_d, count_d} = step_down(count_q);
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge btn_reset) begin
        if (!btn_reset) begin
            count_q     <= INIT_CNT;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
    assign at_max    = (count_q == MAX_CNT);
    assign at_min    = (count_q == ZERO_CNT);

endmodule

// File: tb/tb_dcounter_sync.sv
// Bench for dcounter_sync: three instances (wrap INIT=0, saturating INIT=14, wrap INIT=5)
// driven in turn; a model queues each expected count event with its due cycle.
module tb_dcounter_sync;

    localparam int DB = 4;

    typedef struct {
        int dut;
        int cyc;
        int cnt;
        bit ovf;
        bit unf;
    } exp_t;

    logic       clk;
    logic       rst_n   [3];
    logic       inc_b   [3];
    logic       dec_b   [3];
    logic [3:0] count   [3];
    logic       at_max  [3];
    logic       at_min  [3];
    logic       ovf     [3];
    logic       unf     [3];
    logic [3:0] prev    [3];

    int   cyc;
    int   n_cmp;
    int   n_err;
    int   mcnt   [3];
    bit   wrap_m [3];
    exp_t sb [$];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        dcounter_sync #(
            .N              (4),
            .DEBOUNCE_CYCLES(DB),
            .WRAP           ((g == 1) ? 0 : 1),
            .INIT           ((g == 0) ? 0 : ((g == 1) ? 14 : 5))
        ) u_dut (
            .clk          (clk),
            .btn_reset    (rst_n[g]),
            .btn_increment(inc_b[g]),
            .btn_decrement(dec_b[g]),
            .count        (count[g]),
            .at_max       (at_max[g]),
            .at_min       (at_min[g]),
            .overflow     (ovf[g]),
            .underflow    (unf[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push_exp(input int g, input bit up);
        exp_t e;
        e.dut = g;
        e.cyc = cyc + 3 + DB;
        e.ovf = 1'b0;
        e.unf = 1'b0;
        if (up) begin
            if (mcnt[g] == 15) begin
                e.ovf = 1'b1;
                if (wrap_m[g]) mcnt[g] = 0;
            end else begin
                mcnt[g]++;
            end
        end else begin
            if (mcnt[g] == 0) begin
                e.unf = 1'b1;
                if (wrap_m[g]) mcnt[g] = 15;
            end else begin
                mcnt[g]--;
            end
        end
        e.cnt = mcnt[g];
        sb.push_back(e);
    endtask

    task automatic press(input int g, input bit up, input bit dn, input int hold);
        @(posedge clk); #1;
        if (up) inc_b[g] = 1'b0;
        if (dn) dec_b[g] = 1'b0;
        if (up ^ dn) push_exp(g, up);
        repeat (hold) @(posedge clk);
        #1;
        inc_b[g] = 1'b1;
        dec_b[g] = 1'b1;
        repeat (10) @(posedge clk);
        #1;
    endtask

    // Any count change or status pulse outside reset must match the head of the queue.
    always @(negedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (!rst_n[g]) begin
                prev[g] = count[g];
            end else if (count[g] != prev[g] || ovf[g] || unf[g]) begin
                check("evt_dut", g, (sb.size() > 0) ? sb[0].dut : -1);
                if (sb.size() > 0 && sb[0].dut == g) begin
                    check("evt_cyc", cyc, sb[0].cyc);
                    check("evt_cnt", int'(count[g]), sb[0].cnt);
                    check("evt_ovf", int'(ovf[g]), int'(sb[0].ovf));
                    check("evt_unf", int'(unf[g]), int'(sb[0].unf));
                    check("evt_at_max", int'(at_max[g]), (sb[0].cnt == 15) ? 1 : 0);
                    check("evt_at_min", int'(at_min[g]), (sb[0].cnt == 0) ? 1 : 0);
                    void'(sb.pop_front());
                end
                prev[g] = count[g];
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, %0d events pending", sb.size());
        $fatal(1, "watchdog");
    end

    initial begin
        cyc    = 0;
        n_cmp  = 0;
        n_err  = 0;
        mcnt   = '{0, 14, 5};
        wrap_m = '{1'b1, 1'b0, 1'b1};
        for (int g = 0; g < 3; g++) begin
            rst_n[g] = 1'b1;
            inc_b[g] = 1'b1;
            dec_b[g] = 1'b1;
        end
        #1;
        for (int g = 0; g < 3; g++) rst_n[g] = 1'b0;
        #1;
        check("rst_cnt0", int'(count[0]), 0);
        check("rst_cnt1", int'(count[1]), 14);
        check("rst_cnt2", int'(count[2]), 5);
        check("rst_at_min0", int'(at_min[0]), 1);
        check("rst_ovf0", int'(ovf[0]), 0);
        check("rst_unf0", int'(unf[0]), 0);
        #30;
        for (int g = 0; g < 3; g++) rst_n[g] = 1'b1;
        repeat (3) @(posedge clk);

        // Single long press: exactly one increment.
        press(0, 1'b1, 1'b0, 20);
        check("single_cnt", int'(count[0]), 1);

        // Bounce: 2-cycle glitches, then the last low run is held.
        @(posedge clk); #1;
        for (int i = 0; i < 40; i++) begin
            inc_b[0] = (i < 30) ? (((i / 2) % 2) == 1) : 1'b0;
            if (i == 28) push_exp(0, 1'b1);
            @(posedge clk); #1;
        end
        inc_b[0] = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("bounce_cnt", int'(count[0]), 2);

        // Mid-cycle reset acts immediately.
        @(posedge clk); #3;
        rst_n[0] = 1'b0;
        #1;
        check("midrst_cnt", int'(count[0]), 0);
        check("midrst_at_min", int'(at_min[0]), 1);
        mcnt[0] = 0;
        @(posedge clk); #3;
        rst_n[0] = 1'b1;
        repeat (2) @(posedge clk);

        // Wrap mode through 15 -> 0 and back to 15.
        repeat (15) press(0, 1'b1, 1'b0, 8);
        check("wrap_at_max", int'(at_max[0]), 1);
        press(0, 1'b1, 1'b0, 8);
        check("wrap_cnt0", int'(count[0]), 0);
        press(0, 1'b0, 1'b1, 8);
        check("wrap_cnt15", int'(count[0]), 15);

        // Simultaneous presses cancel.
        press(0, 1'b1, 1'b1, 10);
        check("simul_cnt", int'(count[0]), 15);

        // Saturating instance.
        repeat (3) press(1, 1'b1, 1'b0, 8);
        check("sat_hi", int'(count[1]), 15);
        repeat (16) press(1, 1'b0, 1'b1, 8);
        check("sat_lo", int'(count[1]), 0);
        check("sat_at_min", int'(at_min[1]), 1);

        // Reset at debounce sample 2 with the decrement button held.
        @(posedge clk); #1;
        dec_b[2] = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n[2] = 1'b0;
        #1;
        check("dbrst_cnt", int'(count[2]), 5);
        @(posedge clk); #2;
        rst_n[2] = 1'b1;
        push_exp(2, 1'b0);
        repeat (14) @(posedge clk);
        #1;
        dec_b[2] = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("dbrst_final", int'(count[2]), 4);

        check("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
